// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and helpers shared by the encoder and the decoder.
package rv_isa_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [2:0] {
    TYPE_NONE = 3'd0,
    TYPE_R    = 3'd1,
    TYPE_I    = 3'd2,
    TYPE_U    = 3'd3,
    TYPE_S    = 3'd4,
    TYPE_B    = 3'd5,
    TYPE_J    = 3'd6,
    TYPE_CSR  = 3'd7
  } inst_type_e;

  // One buffered result word; the address lives beside it because its width is a parameter.
  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_word_t;

  function automatic inst_type_e opcode_type(input logic [6:0] opc);
    case (opc)
      OPC_OP:                       return TYPE_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return TYPE_I;
      OPC_LUI, OPC_AUIPC:           return TYPE_U;
      OPC_STORE:                    return TYPE_S;
      OPC_BRANCH:                   return TYPE_B;
      OPC_JAL:                      return TYPE_J;
      OPC_SYSTEM:                   return TYPE_CSR;
      default:                      return TYPE_NONE;
    endcase
  endfunction

  // True when value survives truncation to a bits-wide two's-complement field.
  function automatic logic fits_signed(input logic [31:0] value, input int unsigned bits);
    logic [31:0] upper;
    upper = 32'($signed(value) >>> (bits - 1));
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/rv_inst_pack.sv
// Combinational field packer: instruction fields to a 32-bit word plus range error.
module rv_inst_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  inst_type_e itype;
  logic       is_shift;

  assign itype    = opcode_type(opcode);
  // slli/srli/srai use func3 001 and 101; both end in 01.
  assign is_shift = (opcode == OPC_OP_IMM) && (func3[1:0] == 2'b01);

  // Select the packing and error rule for the decoded instruction type.
  always_comb begin
    inst = NOP_INST;
    err  = 1'b1;
    case (itype)
      TYPE_R: begin
        inst = {func7, rs2, rs1, func3, rd, opcode};
        err  = 1'b0;
      end
      TYPE_I: begin
        if (is_shift) begin
          inst = {func7, imm[4:0], rs1, func3, rd, opcode};
          err  = (imm[31:5] != '0);
        end else begin
          inst = {imm[11:0], rs1, func3, rd, opcode};
          err  = !fits_signed(imm, 12);
        end
      end
      TYPE_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = (imm[11:0] != '0);
      end
      TYPE_S: begin
        inst = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
        err  = !fits_signed(imm, 12);
      end
      TYPE_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
        err  = !fits_signed(imm, 13) || imm[0];
      end
      TYPE_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !fits_signed(imm, 21) || imm[0];
      end
      TYPE_CSR: begin
        inst = {imm[11:0], rs1, func3, rd, opcode};
        err  = (imm[31:12] != '0);
      end
      default: begin
        inst = NOP_INST;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv_inst_encoder.sv
// RV32I encoder: packs field sets, tags them with byte addresses and queues them in a 2-entry buffer.
module rv_inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  logic [31:0]       pack_inst;
  logic              pack_err;
  enc_word_t         buf_word [2];
  logic [ADDR_W-1:0] buf_addr [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic              in_ready_q;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        err_cnt_q;
  logic              push;
  logic              pop;

  rv_inst_pack u_pack (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .func3  (in_func3),
    .func7  (in_func7),
    .imm    (in_imm),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  // clear masks the handshake in its own cycle so no word slips in while flushing.
  assign in_ready  = in_ready_q & ~clear;
  assign push      = in_valid & in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready & ~clear;
  assign out_inst  = buf_word[rd_ptr].inst;
  assign out_err   = buf_word[rd_ptr].err;
  assign out_addr  = buf_addr[rd_ptr];
  assign err_count = err_cnt_q;

  // Next occupancy; also feeds the registered ready.
  always_comb begin
    count_nxt = count;
    if (clear) count_nxt = 2'd0;
    else       count_nxt = count + 2'(push) - 2'(pop);
  end

  // Buffer storage and pointers; reset clears entries so outputs idle at zero / BASE_ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_word[i] <= '0;
        buf_addr[i] <= BASE_ADDR;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_word[wr_ptr] <= '{inst: pack_inst, err: pack_err};
        buf_addr[wr_ptr] <= addr_cnt;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

  // Ready, address counter and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
      addr_cnt   <= BASE_ADDR;
      err_cnt_q  <= 8'd0;
    end else begin
      in_ready_q <= (count_nxt != 2'd2);
      if (clear) begin
        addr_cnt  <= BASE_ADDR;
        err_cnt_q <= 8'd0;
      end else if (push) begin
        addr_cnt <= addr_cnt + ADDR_W'(ADDR_STEP);
        if (pack_err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Self-checking bench: scoreboard model of the encoder, directed scenarios, then random traffic.
module tb_rv_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_func3 = '0;
  logic [6:0]  in_func7 = '0;
  logic [31:0] in_imm = '0;

  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst;
  logic [15:0] out_addr;
  logic [7:0]  err_count;
  logic        w4_in_ready, w4_out_valid, w4_out_err;
  logic [31:0] w4_out_inst;
  logic [3:0]  w4_out_addr;
  logic [7:0]  w4_err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv_inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  rv_inst_encoder #(.ADDR_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(w4_in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm),
    .out_valid(w4_out_valid), .out_ready(out_ready), .out_inst(w4_out_inst),
    .out_addr(w4_out_addr), .out_err(w4_out_err), .err_count(w4_err_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the ISA field layout, using integer arithmetic.
  task automatic ref_encode(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm, output logic [31:0] inst, output logic err);
    int s;
    logic [31:0] rest;
    s = $signed(imm);
    rest = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
    inst = 32'h00000013;
    err = 1'b1;
    if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      inst = (32'(f7) << 25) | ((imm & 32'd31) << 20) | rest;
      err = (imm > 32'd31);
    end else if (opc == 7'h13 || opc == 7'h03 || opc == 7'h67) begin
      inst = ((imm & 32'hFFF) << 20) | rest;
      err = (s < -2048) || (s > 2047);
    end else if (opc == 7'h73) begin
      inst = ((imm & 32'hFFF) << 20) | rest;
      err = (imm > 32'd4095);
    end else if (opc == 7'h33) begin
      inst = (32'(f7) << 25) | (32'(rs2) << 20) | rest;
      err = 1'b0;
    end else if (opc == 7'h37 || opc == 7'h17) begin
      inst = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(opc);
      err = ((imm & 32'hFFF) != 0);
    end else if (opc == 7'h23) begin
      inst = (((imm >> 5) & 32'd127) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
             (32'(f3) << 12) | ((imm & 32'd31) << 7) | 32'(opc);
      err = (s < -2048) || (s > 2047);
    end else if (opc == 7'h63) begin
      inst = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) |
             (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
             (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'(opc);
      err = (s < -4096) || (s > 4095) || ((imm & 32'd1) != 0);
    end else if (opc == 7'h6F) begin
      inst = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) |
             (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) |
             (32'(rd) << 7) | 32'(opc);
      err = (s < -1048576) || (s > 1048575) || ((imm & 32'd1) != 0);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          addr;
  } exp_t;

  exp_t q[$];
  int   m_addr = 0;
  int   m_errs = 0;
  bit   m_rdy = 1'b0;

  // Behavioural model: a queue of expected words, updated at each active edge.
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    logic [31:0] ei;
    logic ee;
    bit acc;
    if (!rst_n) begin
      q.delete();
      m_addr = 0;
      m_errs = 0;
      m_rdy = 1'b0;
    end else begin
      if (clear) begin
        q.delete();
        m_addr = 0;
        m_errs = 0;
      end else begin
        acc = in_valid && m_rdy;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm, ei, ee);
          e.inst = ei;
          e.err = ee;
          e.addr = m_addr;
          q.push_back(e);
          m_addr = m_addr + 4;
          if (ee && m_errs < 255) m_errs++;
        end
      end
      m_rdy = (q.size() < 2);
    end
  end

  // Compare both DUT instances against the model every cycle.
  always @(negedge clk) begin
    exp_t h;
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("w4_out_valid", 32'(w4_out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(m_rdy && !clear));
    chk("w4_in_ready", 32'(w4_in_ready), 32'(m_rdy && !clear));
    chk("err_count", 32'(err_count), 32'(m_errs));
    chk("w4_err_count", 32'(w4_err_count), 32'(m_errs));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_inst", out_inst, h.inst);
      chk("out_err", 32'(out_err), 32'(h.err));
      chk("out_addr", 32'(out_addr), 32'(h.addr & 32'hFFFF));
      chk("w4_out_inst", w4_out_inst, h.inst);
      chk("w4_out_addr", 32'(w4_out_addr), 32'(h.addr & 32'hF));
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    int n;
    n = 0;
    in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_func7 = f7; in_imm = imm;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept t=%0t", $time);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #2;
    clear = 1'b0;
  endtask

  function automatic logic [31:0] pick_imm();
    logic [31:0] bnd [14];
    bnd = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4096,
            32'hFFFFF000, 32'hFFFFEFFE, 32'h000FFFFE, 32'h00100000, 32'hFFF00000,
            32'hFFEFFFFE, 32'd31, 32'd32};
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       return 32'($urandom_range(0, 63));
      3:       return (32'($urandom_range(0, 1048575)) << 12) | 32'($urandom_range(0, 1) * 4);
      4:       return bnd[$urandom_range(0, 13)];
      default: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
    endcase
  endfunction

  logic [31:0] pin_inst;
  logic        pin_err;

  initial begin
    logic [6:0] opcs [12];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h23, 7'h63, 7'h6F, 7'h73, 7'h7F, 7'h00};

    // Pin the model against hand-encoded words.
    ref_encode(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, pin_inst, pin_err);
    chk("pin_addi", pin_inst, 32'hFFF10093);
    ref_encode(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, pin_inst, pin_err);
    chk("pin_add", pin_inst, 32'h002081B3);
    ref_encode(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, pin_inst, pin_err);
    chk("pin_beq", pin_inst, 32'h00208463);
    ref_encode(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, pin_inst, pin_err);
    chk("pin_jal", pin_inst, 32'h001000EF);
    ref_encode(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, pin_inst, pin_err);
    chk("pin_addi_err", 32'(pin_err), 32'd1);

    // Reset values.
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // addi x1,x2,-1 visible one edge after acceptance.
    send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_inst", out_inst, 32'hFFF10093);
    chk("addi_addr", 32'(out_addr), 32'd0);
    chk("addi_err", 32'(out_err), 32'd0);

    // add, beq back-to-back, then jal, from a freshly cleared address.
    do_clear();
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk("add_inst", out_inst, 32'h002081B3);
    chk("add_addr", 32'(out_addr), 32'd0);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    chk("beq_inst", out_inst, 32'h00208463);
    chk("beq_addr", 32'(out_addr), 32'd4);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("jal_inst", out_inst, 32'h001000EF);
    chk("jal_addr", 32'(out_addr), 32'd8);

    // Error words and saturation.
    do_clear();
    send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    chk("addi2048_err", 32'(out_err), 32'd1);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
    chk("beq7_err", 32'(out_err), 32'd1);
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    chk("illegal_inst", out_inst, 32'h00000013);
    chk("illegal_err", 32'(out_err), 32'd1);
    chk("err_count_3", 32'(err_count), 32'd3);
    repeat (300) send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("err_count_sat", 32'(err_count), 32'd255);

    // Backpressure: third word held until the consumer drains.
    do_clear();
    out_ready = 1'b0;
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    in_opcode = 7'h6F; in_rd = 5'd1; in_imm = 32'd2048; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head_inst", out_inst, 32'h002081B3);
    chk("bp_head_addr", 32'(out_addr), 32'd0);
    out_ready = 1'b1;
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    repeat (3) @(posedge clk);
    #2;

    // Clear with a full buffer and a pending word.
    out_ready = 1'b0;
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("pre_clear_errs", 32'(err_count), 32'd2);
    in_opcode = 7'h13; in_valid = 1'b1; clear = 1'b1;
    #1;
    chk("ready_during_clear", 32'(in_ready), 32'd0);
    @(posedge clk); #2;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    chk("clear_err_count", 32'(err_count), 32'd0);
    out_ready = 1'b1;
    send(7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd100);
    chk("post_clear_addr", 32'(out_addr), 32'd0);

    // Async reset mid-cycle with one word buffered.
    out_ready = 1'b0;
    send(7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_addr", 32'(out_addr), 32'd0);
    chk("arst_w4_addr", 32'(w4_out_addr), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;

    // Address wrap on the 4-bit instance.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(7'h13, 5'(i), 5'd1, 5'd0, 3'd0, 7'd0, 32'(i));
    chk("wrap_w4_addr", 32'(w4_out_addr), 32'd0);
    chk("wrap_addr", 32'(out_addr), 32'd16);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      in_opcode = opcs[$urandom_range(0, 11)];
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_func3  = 3'($urandom);
      in_func7  = 7'($urandom);
      in_imm    = pick_imm();
      @(posedge clk); #2;
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
- Inverse of the instruction decode stage. Accepts RV32I instruction fields (opcode, rd, rs1, rs2, func3, func7, imm) over a valid/ready handshake.
- Packs each field set into a 32-bit instruction word, range-checks the immediate, and tags the word with a sequential byte address.
- Results go through a 2-entry output buffer to an instruction-memory loader or to the test harness.
- Also serves as the golden generator for decoder regression.

Parameters:
ADDR_W, 16, width of out_addr (byte address)
BASE_ADDR, 0, address assigned to the first word after reset or clear
ADDR_STEP, 4, address increment per accepted word

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous: flush buffer, reload address, zero error count
in_valid  in  1  field set present
in_ready  out  1  encoder can accept (registered)
in_opcode  in  7  opcode field
in_rd  in  5  destination register
in_rs1  in  5  source 1 register (zimm for CSR)
in_rs2  in  5  source 2 register
in_func3  in  3  func3
in_func7  in  7  func7 (R-type and shift-immediate)
in_imm  in  32  full-width immediate; for CSR, imm[11:0] is the CSR address
out_valid  out  1  out_inst/out_addr/out_err valid
out_ready  in  1  consumer accepts
out_inst  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_inst
out_err  out  1  word had an illegal opcode or out-of-range immediate
err_count  out  8  saturating count of accepted words with err

Behaviour:
- Reset (rst_n low, async): buffer empty, out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, address counter=BASE_ADDR, err_count=0. in_ready becomes 1 on the first clk edge after deassertion.
- Type from opcode:
  - 0110011 = R
  - 0010011 / 0000011 / 1100111 = I
  - 0110111 / 0010111 = U
  - 0100011 = S
  - 1100011 = B
  - 1101111 = J
  - 1110011 = CSR
  - anything else is illegal
- Packing, MSB→LSB:
  - R: {func7, rs2, rs1, func3, rd, opcode}
  - I: {imm[11:0], rs1, func3, rd, opcode}
  - I-shift (opcode 0010011, func3 001 or 101): {func7, imm[4:0], rs1, func3, rd, opcode}
  - U: {imm[31:12], rd, opcode}
  - S: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - CSR: {imm[11:0], rs1, func3, rd, opcode}
- Error rules (err=1):
  - I/S: imm not sign-representable in 12 bits.
  - B: imm not in 13 bits signed, or imm[0]=1.
  - J: imm not in 21 bits signed, or imm[0]=1.
  - U: imm[11:0]≠0.
  - I-shift: imm[31:5]≠0.
  - CSR: imm[31:12]≠0.
  - Illegal opcode: out_inst forced to 32'h00000013 (NOP).
  - Otherwise truncated bits are packed as-is.
- Accept = in_valid & in_ready. Each accepted word is written into the buffer with addr = counter, then the counter advances by ADDR_STEP, wrapping mod 2^ADDR_W.
- Latency: word accepted at edge N is visible on out_* after edge N (out_valid high in cycle N+1) when the buffer was empty. Throughput is 1 word/cycle while out_ready=1.
- Buffer: 2-entry FIFO, order preserved. Pop = out_valid & out_ready. Head outputs are held stable while out_valid & !out_ready.
- in_ready = (count<2) & !clear, registered from next-state count.
- Count 2: in_ready=0, no push that cycle. Count 1 with push+pop: stays at 1. Count 0: in_ready=1.
- err_count increments on accept when err=1 and saturates at 255.
- clear wins over everything in the same cycle:
  - push and pop are ignored; the buffer empties; out_valid=0 next cycle.
  - counter=BASE_ADDR, err_count=0; in_ready=0 during the clear cycle.
- rst_n asserted mid-stream: all buffered words are discarded immediately.

Decomposition:
- Package rv_isa_pkg, shared with the decoder:
  - opcode localparams and type codes (R=1, I=2, U=3, S=4, B=5, J=6, CSR=7, NONE=0)
  - NOP constant 32'h00000013
- Sub-module rv_inst_pack, purely combinational: fields → {inst, err}.
- Top holds the FIFO, address counter and err_count.

Test Plan:
- addi x1,x2,-1 (opc 0010011, rd 1, rs1 2, f3 0, imm FFFFFFFF), out_ready=1 → next cycle out_inst=FFF10093, out_err=0, out_addr=0.
- add x3,x1,x2 then beq x1,x2,+8 back-to-back → 002081B3 @0, 00208463 @4. jal x1,+2048 → 001000EF @8.
- Error words: addi imm=2048 → err=1; beq imm=7 → err=1; opcode 1111111 → out_inst=00000013, err=1; err_count=3. Force 300 bad words → err_count=255.
- out_ready=0, push 3 words → in_ready falls after 2 accepts, third held; raise out_ready → 3 words in order at addrs 0,4,8, no loss or duplication.
- Buffer holds 2 words and clear is asserted with in_valid=1 → next cycle out_valid=0, err_count=0. Next accepted word gets addr=BASE_ADDR.
- rst_n pulsed low asynchronously mid-cycle with 1 word buffered → out_valid drops immediately, out_addr=BASE_ADDR. ADDR_W=4 wrap: 5th word addr wraps 12→0.
